// File: rtl/commutation_sequencer_pkg.sv
// Shared definitions for the six-step commutation sequencer: drive pattern
// table, step count, FSM state encoding and the step-advance helper.
package commutation_sequencer_pkg;

    localparam int NUM_STEPS = 6;

    localparam logic [7:0] PAT_0 = 8'h90;
    localparam logic [7:0] PAT_1 = 8'h18;
    localparam logic [7:0] PAT_2 = 8'h48;
    localparam logic [7:0] PAT_3 = 8'h60;
    localparam logic [7:0] PAT_4 = 8'h24;
    localparam logic [7:0] PAT_5 = 8'h84;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    // Next table index in the given direction (0 = forward, 1 = reverse),
    // wrapping at both ends. Out-of-range indices fall back into the table.
    function automatic logic [2:0] next_step_idx(input logic [2:0] idx, input logic dir);
        logic [2:0] nxt;
        if (!dir) begin
            nxt = (idx >= 3'(NUM_STEPS - 1)) ? 3'd0 : idx + 3'd1;
        end else begin
            nxt = (idx == 3'd0 || idx > 3'(NUM_STEPS - 1)) ? 3'(NUM_STEPS - 1) : idx - 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/commutation_pattern_rom.sv
// Combinational lookup of the six drive patterns; unused indices give all-off.
module commutation_pattern_rom
    import commutation_sequencer_pkg::*;
(
    input  logic [2:0] idx,
    output logic [7:0] pattern
);

    // Table decode, defaulting to all-off so an illegal index can never drive a leg
    always_comb begin
        pattern = 8'h00;
        case (idx)
            3'd0:    pattern = PAT_0;
            3'd1:    pattern = PAT_1;
            3'd2:    pattern = PAT_2;
            3'd3:    pattern = PAT_3;
            3'd4:    pattern = PAT_4;
            3'd5:    pattern = PAT_5;
            default: pattern = 8'h00;
        endcase
    end

endmodule

// File: rtl/commutation_sequencer.sv
// Timed six-step commutation controller: holds each pattern for a programmable
// number of cycles, inserts optional all-off dead time between steps, runs in
// either direction and takes new configuration only at step boundaries.
module commutation_sequencer
    import commutation_sequencer_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int DEAD_W   = 4,
    parameter int OUT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [DEAD_W-1:0]   cfg_dead,
    input  logic                cfg_dir,
    output logic [OUT_W-1:0]    drive,
    output logic [2:0]          step_idx,
    output logic                step_pulse,
    output logic                busy
);

    state_t              state_reg;
    logic [PERIOD_W-1:0] cnt_reg;

    // Active configuration
    logic [PERIOD_W-1:0] act_period_reg;
    logic [DEAD_W-1:0]   act_dead_reg;
    logic                act_dir_reg;

    // One-entry shadow holding an accepted but not yet applied configuration
    logic                sh_valid_reg;
    logic [PERIOD_W-1:0] sh_period_reg;
    logic [DEAD_W-1:0]   sh_dead_reg;
    logic                sh_dir_reg;

    // Output registers
    logic [OUT_W-1:0]    drive_reg;
    logic [2:0]          step_idx_reg;
    logic                step_pulse_reg;
    logic                busy_reg;
    logic                cfg_ready_reg;

    logic [PERIOD_W-1:0] eff_period;
    logic                eff_dir;
    logic [PERIOD_W-1:0] period_load;
    logic [PERIOD_W-1:0] dead_load;
    logic [2:0]          adv_idx;
    logic [2:0]          rom_idx;
    logic [7:0]          rom_pattern;
    logic                cfg_fire;

    // Settings that take effect at the next step start: the shadow if one is
    // pending (it is applied at that moment), otherwise the active set
    always_comb begin
        eff_period  = sh_valid_reg ? sh_period_reg : act_period_reg;
        eff_dir     = sh_valid_reg ? sh_dir_reg    : act_dir_reg;
        period_load = (eff_period == '0) ? '0 : eff_period - PERIOD_W'(1);
        dead_load   = PERIOD_W'(act_dead_reg) - PERIOD_W'(1);
        adv_idx     = next_step_idx(step_idx_reg, eff_dir);
        // Leaving IDLE restarts the retained step; elsewhere we load the advanced one
        rom_idx     = (state_reg == ST_IDLE) ? step_idx_reg : adv_idx;
        cfg_fire    = cfg_valid & cfg_ready_reg;
    end

    commutation_pattern_rom u_rom (
        .idx     (rom_idx),
        .pattern (rom_pattern)
    );

    // Sequencer FSM with counters, config shadow and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            act_period_reg <= PERIOD_W'(1);
            act_dead_reg   <= '0;
            act_dir_reg    <= 1'b0;
            sh_valid_reg   <= 1'b0;
            sh_period_reg  <= '0;
            sh_dead_reg    <= '0;
            sh_dir_reg     <= 1'b0;
            drive_reg      <= '0;
            step_idx_reg   <= 3'd0;
            step_pulse_reg <= 1'b0;
            busy_reg       <= 1'b0;
            cfg_ready_reg  <= 1'b1;
        end else begin
            step_pulse_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    drive_reg <= '0;
                    if (sh_valid_reg) begin
                        act_period_reg <= sh_period_reg;
                        act_dead_reg   <= sh_dead_reg;
                        act_dir_reg    <= sh_dir_reg;
                        sh_valid_reg   <= 1'b0;
                        cfg_ready_reg  <= 1'b1;
                    end
                    if (run) begin
                        state_reg      <= ST_DRIVE;
                        busy_reg       <= 1'b1;
                        drive_reg      <= OUT_W'(rom_pattern);
                        step_pulse_reg <= 1'b1;
                        cnt_reg        <= period_load;
                    end
                end
                ST_DRIVE, ST_DEAD: begin
                    if (!run) begin
                        // Stop takes priority over any boundary; the step is kept
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        drive_reg <= '0;
                        cnt_reg   <= '0;
                    end else if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - PERIOD_W'(1);
                    end else if (state_reg == ST_DRIVE && act_dead_reg != '0) begin
                        state_reg <= ST_DEAD;
                        drive_reg <= '0;
                        cnt_reg   <= dead_load;
                    end else begin
                        // Step boundary: advance and apply any pending configuration
                        state_reg      <= ST_DRIVE;
                        step_idx_reg   <= adv_idx;
                        drive_reg      <= OUT_W'(rom_pattern);
                        step_pulse_reg <= 1'b1;
                        cnt_reg        <= period_load;
                        if (sh_valid_reg) begin
                            act_period_reg <= sh_period_reg;
                            act_dead_reg   <= sh_dead_reg;
                            act_dir_reg    <= sh_dir_reg;
                            sh_valid_reg   <= 1'b0;
                            cfg_ready_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    drive_reg <= '0;
                    cnt_reg   <= '0;
                end
            endcase
            // Acceptance only happens with an empty shadow, so it never
            // collides with an apply on the same edge
            if (cfg_fire) begin
                sh_valid_reg  <= 1'b1;
                sh_period_reg <= cfg_period;
                sh_dead_reg   <= cfg_dead;
                sh_dir_reg    <= cfg_dir;
                cfg_ready_reg <= 1'b0;
            end
        end
    end

    assign drive      = drive_reg;
    assign step_idx   = step_idx_reg;
    assign step_pulse = step_pulse_reg;
    assign busy       = busy_reg;
    assign cfg_ready  = cfg_ready_reg;

endmodule

// File: tb/tb_commutation_sequencer.sv
// Directed and randomized stimulus for the commutation sequencer, checked
// every cycle against a step/phase-level behavioural model.
module tb_commutation_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [3:0]  cfg_dead;
    logic        cfg_dir;
    logic [7:0]  drive;
    logic [2:0]  step_idx;
    logic        step_pulse;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    commutation_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_dead   (cfg_dead),
        .cfg_dir    (cfg_dir),
        .drive      (drive),
        .step_idx   (step_idx),
        .step_pulse (step_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int tab [6] = '{8'h90, 8'h18, 8'h48, 8'h60, 8'h24, 8'h84};
    bit m_run, m_dead, m_adir, m_sv, m_sdir, e_pulse;
    int m_left, m_idx, m_ap, m_ad, m_sp, m_sd, e_drive;

    function automatic int eff(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    function automatic void model_reset();
        m_run = 0; m_dead = 0; m_left = 0; m_idx = 0;
        m_ap = 1; m_ad = 0; m_adir = 0;
        m_sv = 0; m_sp = 0; m_sd = 0; m_sdir = 0;
        e_drive = 0; e_pulse = 0;
    endfunction

    function automatic void model_apply();
        if (m_sv) begin
            m_ap = m_sp; m_ad = m_sd; m_adir = m_sdir; m_sv = 0;
        end
    endfunction

    // One clock edge of the model, using the inputs presented before the edge
    function automatic void model_edge();
        bit acc = cfg_valid && !m_sv;
        e_pulse = 0;
        if (!m_run) begin
            model_apply();
            if (run) begin
                m_run = 1; m_dead = 0; m_left = eff(m_ap);
                e_drive = tab[m_idx]; e_pulse = 1;
            end else begin
                e_drive = 0;
            end
        end else if (!run) begin
            m_run = 0; m_dead = 0; e_drive = 0;
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (!m_dead && m_ad > 0) begin
                    m_dead = 1; m_left = m_ad; e_drive = 0;
                end else begin
                    model_apply();
                    m_idx = m_adir ? (m_idx + 5) % 6 : (m_idx + 1) % 6;
                    m_dead = 0; m_left = eff(m_ap);
                    e_drive = tab[m_idx]; e_pulse = 1;
                end
            end
        end
        if (acc) begin
            m_sv = 1; m_sp = int'(cfg_period); m_sd = int'(cfg_dead); m_sdir = cfg_dir;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_drive"},  16'(drive),      16'(e_drive));
        chk({tag, "_idx"},    16'(step_idx),   16'(m_idx));
        chk({tag, "_pulse"},  16'(step_pulse), 16'(e_pulse));
        chk({tag, "_busy"},   16'(busy),       16'(m_run));
        chk({tag, "_ready"},  16'(cfg_ready),  16'(!m_sv));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all({tag, "_async"});
        @(posedge clk);
        #1;
        compare_all({tag, "_held"});
        #2;
        reset = 1'b0;
    endtask

    task automatic send_cfg(input int p, input int d, input bit dir);
        cfg_valid  = 1'b1;
        cfg_period = 16'(p);
        cfg_dead   = 4'(d);
        cfg_dir    = dir;
        cycle("cfg");
        cfg_valid  = 1'b0;
    endtask

    int seq2 [7] = '{8'h90, 8'h84, 8'h24, 8'h60, 8'h48, 8'h18, 8'h90};
    int guard;

    initial begin
        run = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_dead = '0; cfg_dir = 1'b0;
        reset = 1'b0;
        model_reset();
        apply_reset("reset");

        // 1: period 4, dead 2, forward, a full revolution and back to 0x90
        send_cfg(4, 2, 0);
        cycle("t1_apply");
        run = 1'b1;
        for (int i = 0; i < 6 * 6 + 1; i++) cycle("t1");
        run = 1'b0;
        cycle("t1_stop");

        // 2: period 1, dead 0, reverse, from idx 0: new pattern every cycle
        apply_reset("t2_rst");
        send_cfg(1, 0, 1);
        cycle("t2_apply");
        run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle("t2");
            chk("t2_seq_drive", 16'(drive), 16'(seq2[i]));
            chk("t2_seq_pulse", 16'(step_pulse), 16'd1);
        end
        run = 1'b0;
        cycle("t2_stop");

        // 3: running at period 3, mid-step change to period 2 reverse
        apply_reset("t3_rst");
        send_cfg(3, 0, 0);
        run = 1'b1;
        for (int i = 0; i < 4; i++) cycle("t3_run");
        send_cfg(2, 0, 1);
        for (int i = 0; i < 10; i++) cycle("t3_after");
        run = 1'b0;
        cycle("t3_stop");

        // 4: stop during dead time at idx 2, then resume at the same step
        apply_reset("t4_rst");
        send_cfg(2, 3, 0);
        run = 1'b1;
        guard = 0;
        while (!(m_dead && m_idx == 2) && guard < 60) begin
            cycle("t4_run");
            guard++;
        end
        chk("t4_reached_dead_idx2", 16'(guard < 60), 16'd1);
        run = 1'b0;
        cycle("t4_stop");
        chk("t4_stop_drive", 16'(drive), 16'h00);
        chk("t4_stop_busy",  16'(busy),  16'd0);
        run = 1'b1;
        cycle("t4_resume");
        chk("t4_resume_drive", 16'(drive),      16'h48);
        chk("t4_resume_pulse", 16'(step_pulse), 16'd1);
        for (int i = 0; i < 4; i++) cycle("t4_more");

        // 5: reset in the middle of the 0x60 step, then restart at idx 0, period 1
        apply_reset("t5_rst");
        send_cfg(3, 0, 0);
        run = 1'b1;
        guard = 0;
        while (!(m_run && m_idx == 3 && m_left == 2) && guard < 40) begin
            cycle("t5_run");
            guard++;
        end
        chk("t5_in_step3", 16'(drive), 16'h60);
        run = 1'b0;
        apply_reset("t5_mid");
        chk("t5_drive_cleared", 16'(drive), 16'h00);
        run = 1'b1;
        cycle("t5_restart");
        chk("t5_restart_drive", 16'(drive), 16'h90);
        chk("t5_restart_idx",   16'(step_idx), 16'd0);
        cycle("t5_next");
        chk("t5_period1_idx", 16'(step_idx), 16'd1);
        run = 1'b0;
        cycle("t5_stop");

        // 6: period 0 behaves as period 1; index stays in range
        send_cfg(0, 0, 0);
        run = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycle("t6");
            chk("t6_idx_range", 16'(step_idx <= 3'd5), 16'd1);
        end

        // Randomized phase: run toggling, config offers, occasional reset
        for (int i = 0; i < 800; i++) begin
            run        = ($urandom_range(0, 19) != 0);
            cfg_valid  = ($urandom_range(0, 5) == 0);
            cfg_period = 16'($urandom_range(0, 4));
            cfg_dead   = 4'($urandom_range(0, 3));
            cfg_dir    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                cfg_valid = 1'b0;
                apply_reset("rnd_rst");
            end else begin
                cycle("rnd");
            end
        end
        run = 1'b0;
        cfg_valid = 1'b0;
        cycle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
